// File: rtl/i2s_dac_tx_pkg.sv
// Shared types and constants for the I2S DAC transmitter: output sample
// format, saturation limits, frame length and serializer states.
package i2s_dac_tx_pkg;

    typedef logic signed [15:0] sample_t;

    localparam sample_t SAT_MAX   = 16'sh7FFF;
    localparam sample_t SAT_MIN   = 16'sh8000;
    localparam int      FRAME_LEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ser_state_t;

endpackage

// File: rtl/i2s_dac_tx_sync_fifo.sv
// Single-clock FIFO with full/empty flags. A push is accepted when full
// if a pop happens in the same cycle. DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// Mono I2S transmitter: shifts and saturates the filterbank sum to 16 bits,
// buffers it, and serializes each sample into both slots of a 32-bit frame.
module i2s_dac_tx
    import i2s_dac_tx_pkg::*;
#(
    parameter int SHIFT      = 10,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic signed [31:0] sample_in,
    output logic               bclk_out,
    output logic               lrclk_out,
    output logic               sdata_out,
    output logic               clip_out,
    output logic               overflow_out,
    output logic               underflow_out
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LR_FIRST = CNT_W'(FRAME_LEN / 2 - 1);
    localparam logic signed [31:0] SAT_HI = {{16{SAT_MAX[15]}}, SAT_MAX};
    localparam logic signed [31:0] SAT_LO = {{16{SAT_MIN[15]}}, SAT_MIN};

    // ---------------- input stage ----------------
    logic signed [31:0] shifted;
    sample_t            sat_s;
    logic               sat_clip;
    sample_t            s_q;
    logic               s_vld;

    assign shifted = sample_in >>> SHIFT;

    always_comb begin
        sat_s    = shifted[15:0];
        sat_clip = 1'b0;
        if (shifted > SAT_HI) begin
            sat_s    = SAT_MAX;
            sat_clip = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_s    = SAT_MIN;
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s_q      <= '0;
            s_vld    <= 1'b0;
            clip_out <= 1'b0;
        end else begin
            s_vld    <= valid_in;
            clip_out <= valid_in && sat_clip;
            if (valid_in) s_q <= sat_s;
        end
    end

    // ---------------- FIFO ----------------
    logic        fifo_pop;
    logic [15:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (s_vld),
        .wdata  (s_q),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Full is judged after the same-cycle pop, so a pop frees a slot first.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) overflow_out <= 1'b0;
        else         overflow_out <= s_vld && fifo_full && !fifo_pop;
    end

    // ---------------- serializer ----------------
    ser_state_t       state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic             bclk, bclk_n;
    logic [CNT_W-1:0] bit_cnt, bit_n;
    logic [31:0]      sr, sr_n;
    logic             unf_n;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bclk          <= 1'b0;
            bit_cnt       <= '0;
            sr            <= '0;
            underflow_out <= 1'b0;
        end else begin
            state         <= state_n;
            div_cnt       <= div_n;
            bclk          <= bclk_n;
            bit_cnt       <= bit_n;
            sr            <= sr_n;
            underflow_out <= unf_n;
        end
    end

    // The IDLE->RUN cycle already counts as the first divider tick, and
    // bit_cnt is parked at the last slot so the first bclk fall loads a frame.
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bclk_n   = bclk;
        bit_n    = bit_cnt;
        sr_n     = sr;
        unf_n    = 1'b0;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = RUN;
                    div_n   = DIV_W'(1);
                    bit_n   = CNT_LAST;
                end
            end
            RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_n  = '0;
                    bclk_n = ~bclk;
                    if (bclk) begin
                        bit_n = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                            if (fifo_empty) begin
                                sr_n  = '0;
                                unf_n = 1'b1;
                            end else begin
                                sr_n     = {fifo_rdata, fifo_rdata};
                                fifo_pop = 1'b1;
                            end
                        end else begin
                            sr_n = {sr[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bclk_out  = bclk;
    assign sdata_out = sr[31];
    assign lrclk_out = (bit_cnt >= LR_FIRST) && (bit_cnt != CNT_LAST);

endmodule

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter SHIFT, default 10: arithmetic right-shift applied to sample_in before saturation.
REQ-002 SHALL have parameter BCLK_DIV, default 4: clk_in cycles per bclk half-period, minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of 16-bit FIFO entries, power of two.
REQ-004 SHALL have one clock, clk_in; reset is rst_in, asynchronous and active-low.
REQ-005 clk_in  input  1  system clock.
REQ-006 rst_in  input  1  asynchronous active-low reset.
REQ-007 valid_in  input  1  one-cycle strobe qualifying sample_in; the source has no backpressure.
REQ-008 sample_in  input  32 signed  summed filterbank output.
REQ-009 bclk_out  output  1  serial bit clock.
REQ-010 lrclk_out  output  1  word select: 0 = left slot, 1 = right slot.
REQ-011 sdata_out  output  1  serial data, MSB first.
REQ-012 clip_out  output  1  one-cycle pulse when a sample saturated.
REQ-013 overflow_out  output  1  one-cycle pulse when a sample was dropped because the FIFO was full.
REQ-014 underflow_out  output  1  one-cycle pulse when a frame started with the FIFO empty.

Function
REQ-015 Input stage SHALL, in the cycle valid_in=1, register s = sample_in >>> SHIFT saturated to [-32768, 32767].
REQ-016 clip_out SHALL pulse in that same registered cycle exactly when saturation occurred.
REQ-017 The saturated sample SHALL be written to the FIFO on the following cycle, giving 2 cycles of latency from valid_in to FIFO occupancy.
REQ-018 If the FIFO is full at write time, the new sample SHALL be dropped, FIFO contents SHALL be unchanged, and overflow_out SHALL pulse for 1 cycle.
REQ-019 A write and a pop in the same cycle SHALL both succeed, including when the FIFO is full; the full check SHALL use occupancy after the pop.
REQ-020 The divider counter SHALL count 0..BCLK_DIV-1 and wrap; bclk_out SHALL toggle on each wrap.
REQ-021 A "bclk fall" is the wrap at which bclk_out goes 1->0; all serial state SHALL update only on bclk falls.
REQ-022 The serializer state machine SHALL have states IDLE and RUN.
REQ-023 In IDLE the divider SHALL be held at 0, bclk_out=0, lrclk_out=0, sdata_out=0.
REQ-024 IDLE->RUN SHALL occur on the first cycle the FIFO is non-empty; RUN SHALL persist until reset.
REQ-025 In RUN, a 5-bit bit_cnt SHALL increment on each bclk fall and wrap 31->0; one frame = 32 bclk periods = 64*BCLK_DIV clk_in cycles (256 at defaults).
REQ-026 At each bclk fall where bit_cnt becomes 0, including the first fall after entering RUN, the serializer SHALL pop the FIFO head h and load a 32-bit shift register with {h, h} (mono duplicated into left and right).
REQ-027 If the FIFO is empty at that load, the shift register SHALL load 0 and underflow_out SHALL pulse for 1 cycle.
REQ-028 On all other bclk falls the shift register SHALL shift left by 1; sdata_out SHALL equal the shift-register MSB.
REQ-029 lrclk_out SHALL be 1 for bit_cnt 15..30 and 0 for 31 and 0..14, so that lrclk leads the data MSB by one bclk.

Reset
REQ-030 While rst_in=0, all outputs SHALL be 0, the FIFO SHALL be empty, the state SHALL be IDLE, and the divider, bit_cnt and shift register SHALL be 0.
REQ-031 Reset SHALL take effect immediately, including mid-frame; the partial frame SHALL be discarded.
REQ-032 After rst_in deasserts, the block SHALL restart from IDLE.

Structure
REQ-033 A shared package SHALL hold the 16-bit output sample typedef, the SAT_MAX (32767) and SAT_MIN (-32768) constants, and the frame length constant (32).
REQ-034 One sub-module, sync_fifo (parameterised width and depth, with full/empty flags), SHALL implement the FIFO; saturation and the serializer SHALL be inline.

Verification
REQ-035 Scenario: sample_in=0x00000400, SHIFT=10, one valid_in -> RUN entered, sdata carries 0x0001 in the left slot and 0x0001 in the right slot, clip_out stays 0.
REQ-036 Scenario: sample_in=0x7FFFFFFF -> slot word 0x7FFF and one clip_out pulse; sample_in=0x80000000 -> slot word 0x8000 and one clip_out pulse.
REQ-037 Scenario: in IDLE with FIFO empty, 5 valid_in strobes 2 cycles apart -> RUN starts and pops the first sample; FIFO holds 4 samples; no overflow_out. A 6th strobe before the next frame start -> exactly one overflow_out pulse.
REQ-038 Scenario: one sample, then no further valid_in -> the next frame outputs all zeros and underflow_out pulses once at the bit_cnt=0 load.
REQ-039 Scenario: check lrclk_out and bclk_out timing -> bclk period = 8 clk_in cycles; lrclk_out rises one bclk before the right-slot MSB; frame = 256 cycles.
REQ-040 Scenario: rst_in pulled low at bit_cnt=20 -> all outputs 0 in the same cycle; after release with an empty FIFO the block stays IDLE.
